anton_neopixel_rx: RTL

NeoPixel (WS2812-style) one-wire decoder: samples the serial line driven by the team's NeoPixel transmitter, classifies each high pulse as a 0 or 1 bit, and assembles 24-bit pixels. It detects the low reset gap that ends a frame. It sits on the receive side of the NeoPixel link: loopback self-test on the board, and the scoreboard front-end in simulation. Timing constants assume 10 MHz, 100 ns per tick.

---
 rtl/anton_neopixel_rx.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/anton_neopixel_rx.sv
// ---------------------------------------------------------------------------
// anton_neopixel_rx
//
// WS2812-style one-wire decoder for the receive side of the NeoPixel link.
// The serial line is synchronised and each high pulse is measured. A pulse of
// THRESHOLD_TICKS or more decodes as 1, and a shorter pulse decodes as 0.
// The decoded bits are packed LSB-first into 24-bit pixels. A low gap of
// RESET_TICKS ends a frame. After reset, and after any protocol error, the
// decoder waits for one full low gap, so it never starts decoding part way
// through a frame.
//
// Ports:
//   CLK_10MHZ    in   1   sole clock, 100 ns per tick
//   RESET        in   1   asynchronous, active-high reset
//   NEO_DIN      in   1   asynchronous serial line
//   PIXEL_DATA   out  24  last completed pixel; first received bit in bit 0
//   PIXEL_VALID  out  1   one-cycle pulse when PIXEL_DATA updates
//   PIXEL_INDEX  out  8   0-based position of PIXEL_DATA within its frame
//   FRAME_DONE   out  1   one-cycle pulse on reset-gap detection
//   ERROR        out  1   one-cycle pulse on a protocol violation
//   BUSY         out  1   high while a frame is being decoded (HIGH/LOW)
// ---------------------------------------------------------------------------
module anton_neopixel_rx #(
    parameter int THRESHOLD_TICKS = 5,
    parameter int MAX_HIGH_TICKS  = 10,
    parameter int RESET_TICKS     = 300
) (
    input  logic        CLK_10MHZ,
    input  logic        RESET,
    input  logic        NEO_DIN,
    output logic [23:0] PIXEL_DATA,
    output logic        PIXEL_VALID,
    output logic [7:0]  PIXEL_INDEX,
    output logic        FRAME_DONE,
    output logic        ERROR,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_e;

    localparam logic [3:0] THRESH     = 4'(THRESHOLD_TICKS);
    localparam logic [3:0] MAX_HIGH   = 4'(MAX_HIGH_TICKS);
    // The low counter already holds the earlier low cycles. The gap is
    // complete when it holds RESET_TICKS-1 and the line is still low.
    localparam logic [8:0] RESET_LAST = 9'(RESET_TICKS - 1);

    logic        sync1_q;
    logic        s_q;
    state_e      state_q,    state_d;
    logic [3:0]  high_cnt_q, high_cnt_d;
    logic [8:0]  low_cnt_q,  low_cnt_d;
    logic [4:0]  bit_cnt_q,  bit_cnt_d;
    logic [7:0]  pix_cnt_q,  pix_cnt_d;
    logic [23:0] shift_q,    shift_d;
    logic [23:0] data_q,     data_d;
    logic [7:0]  index_q,    index_d;
    logic        valid_q,    valid_d;
    logic        done_q,     done_d;
    logic        err_q,      err_d;

    logic        bit_val;
    logic [3:0]  high_inc;
    logic [8:0]  low_inc;

    // State register, synchroniser and output pulse registers.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge CLK_10MHZ or posedge RESET) begin
        if (RESET) begin
            sync1_q    <= 1'b0;
            s_q        <= 1'b0;
            state_q    <= ST_SYNC;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            pix_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            index_q    <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync1_q    <= NEO_DIN;
            s_q        <= sync1_q;
            state_q    <= state_d;
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            index_q    <= index_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // case statement can leave a value unassigned and infer a latch.
        state_d    = state_q;
        high_cnt_d = high_cnt_q;
        low_cnt_d  = low_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        index_d    = index_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        bit_val  = (high_cnt_q >= THRESH);
        high_inc = (high_cnt_q == 4'hF) ? high_cnt_q : high_cnt_q + 4'd1;
        low_inc  = (low_cnt_q == 9'h1FF) ? low_cnt_q : low_cnt_q + 9'd1;

        case (state_q)
            ST_SYNC: begin
                if (s_q) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q >= RESET_LAST) begin
                    // The decoder is now aligned to a frame boundary, but it
                    // saw no frame, so it reports no FRAME_DONE.
                    state_d   = ST_IDLE;
                    low_cnt_d = '0;
                end else begin
                    low_cnt_d = low_inc;
                end
            end

            ST_IDLE: begin
                bit_cnt_d = '0;
                pix_cnt_d = '0;
                if (s_q) begin
                    state_d    = ST_HIGH;
                    high_cnt_d = 4'd1;
                end
            end

            ST_HIGH: begin
                if (s_q) begin
                    if (high_cnt_q >= MAX_HIGH) begin
                        err_d      = 1'b1;
                        state_d    = ST_SYNC;
                        high_cnt_d = '0;
                        low_cnt_d  = '0;
                    end else begin
                        high_cnt_d = high_inc;
                    end
                end else begin
                    shift_d[bit_cnt_q] = bit_val;
                    state_d            = ST_LOW;
                    low_cnt_d          = 9'd1;
                    if (bit_cnt_q == 5'd23) begin
                        // Bits 0..22 come from shift_q. Bit 23 is the bit
                        // decoded now, so the pixel is published at once.
                        data_d    = {bit_val, shift_q[22:0]};
                        valid_d   = 1'b1;
                        index_d   = pix_cnt_q;
                        pix_cnt_d = pix_cnt_q + 8'd1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end

            ST_LOW: begin
                if (s_q) begin
                    state_d    = ST_HIGH;
                    high_cnt_d = 4'd1;
                end else if (low_cnt_q >= RESET_LAST) begin
                    // End of frame. A partial pixel is dropped and flagged.
                    done_d    = 1'b1;
                    err_d     = (bit_cnt_q != 5'd0);
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    pix_cnt_d = '0;
                    low_cnt_d = '0;
                end else begin
                    low_cnt_d = low_inc;
                end
            end

            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        PIXEL_DATA  = data_q;
        PIXEL_VALID = valid_q;
        PIXEL_INDEX = index_q;
        FRAME_DONE  = done_q;
        ERROR       = err_q;
        BUSY        = (state_q == ST_HIGH) || (state_q == ST_LOW);
    end

endmodule
